// File: rtl/td4x_pkg.sv
// td4x_pkg: opcode map, FSM states and shared widths
// for the td4x multi-cycle core.
package td4x_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_ADD_AB = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_SUB_A  = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_JC     = 4'b1100,
    OP_HLT    = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/td4x_exec.sv
// td4x_exec: combinational next-register function for one
// instruction held in IR.
module td4x_exec
  import td4x_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = OPC_W + W
) (
  input  logic [IW-1:0] ir,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cf,
  input  logic [W-1:0]  ip,
  input  logic [W-1:0]  in_data,
  output logic [W-1:0]  a_n,
  output logic [W-1:0]  b_n,
  output logic          cf_n,
  output logic [W-1:0]  ip_n,
  output logic [W-1:0]  out_n,
  output logic          out_we,
  output logic          halt
);

  always_comb begin
    opcode_e      op;
    logic [W-1:0] imm;
    logic [W:0]   sum;
    op     = opcode_e'(ir[IW-1:W]);
    imm    = ir[W-1:0];
    sum    = '0;
    a_n    = a;
    b_n    = b;
    cf_n   = 1'b0;
    ip_n   = ip + {{(W-1){1'b0}}, 1'b1};
    out_n  = '0;
    out_we = 1'b0;
    halt   = 1'b0;
    unique case (op)
      OP_ADD_A: begin
        sum         = {1'b0, a} + {1'b0, imm};
        {cf_n, a_n} = sum;
      end
      OP_MOV_AB: a_n = b;
      OP_IN_A:   a_n = in_data;
      OP_MOV_AI: a_n = imm;
      OP_MOV_BA: b_n = a;
      OP_ADD_B: begin
        sum         = {1'b0, b} + {1'b0, imm};
        {cf_n, b_n} = sum;
      end
      OP_IN_B:   b_n = in_data;
      OP_MOV_BI: b_n = imm;
      OP_ADD_AB: begin
        sum         = {1'b0, a} + {1'b0, b};
        {cf_n, a_n} = sum;
      end
      OP_OUT_B: begin
        out_n  = b;
        out_we = 1'b1;
      end
      // Top bit of the widened difference is the borrow.
      OP_SUB_A: begin
        sum         = {1'b0, a} - {1'b0, imm};
        {cf_n, a_n} = sum;
      end
      OP_OUT_I: begin
        out_n  = imm;
        out_we = 1'b1;
      end
      OP_JC:  if (cf) ip_n = imm;
      OP_HLT: begin
        ip_n = ip;
        halt = 1'b1;
      end
      OP_JNC: if (!cf) ip_n = imm;
      OP_JMP: ip_n = imm;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// td4x_core: fetch/execute FSM and architectural registers
// around td4x_exec, with a req/ack instruction port.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int           W         = 4,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter int           IW        = OPC_W + W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          imem_req,
  output logic [W-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic [W-1:0]  in_data,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic          halted
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ip;
    logic         cf;
  } regs_t;

  state_e        state_q, state_d;
  regs_t         regs_q, regs_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic [W-1:0]  x_a, x_b, x_ip, x_out;
  logic          x_cf, x_we, x_halt;

  td4x_exec #(.W(W), .IW(IW)) u_exec (
    .ir      (ir_q),
    .a       (regs_q.a),
    .b       (regs_q.b),
    .cf      (regs_q.cf),
    .ip      (regs_q.ip),
    .in_data (in_data),
    .a_n     (x_a),
    .b_n     (x_b),
    .cf_n    (x_cf),
    .ip_n    (x_ip),
    .out_n   (x_out),
    .out_we  (x_we),
    .halt    (x_halt)
  );

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    ir_d        = ir_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        regs_d = '{a: x_a, b: x_b, ip: x_ip, cf: x_cf};
        if (x_we) begin
          out_d       = x_out;
          out_valid_d = 1'b1;
        end
        if (x_halt)   state_d = ST_HALT;
        else if (run) state_d = ST_REQ;
        else          state_d = ST_IDLE;
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      regs_q      <= '{a: '0, b: '0, ip: RESET_VEC, cf: 1'b0};
      ir_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = regs_q.ip;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: directed vectors for td4x_core at W=4 and W=8
// against a wait-state instruction memory model.
module tb_td4x_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // W=4 instance
  logic       rst4, run4, req4, ack4, ov4, halt4;
  logic [3:0] addr4, in4, out4;
  logic [7:0] data4, cur4;
  int         dly4 = 0, cnt4 = 0;

  td4x_core #(.W(4)) dut4 (
    .clk(clk), .rst(rst4), .run(run4),
    .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_data(data4),
    .in_data(in4), .out_data(out4),
    .out_valid(ov4), .halted(halt4)
  );

  always @(negedge clk) begin
    if (req4) begin
      if (cnt4 == dly4) begin
        ack4  <= 1'b1;
        data4 <= cur4;
      end else begin
        ack4 <= 1'b0;
        cnt4 <= cnt4 + 1;
      end
    end else begin
      ack4 <= 1'b0;
      cnt4 <= 0;
    end
  end

  // W=8 instance, ack can be overridden by hand
  logic        rst8, run8, req8, ov8, halt8, ack8;
  logic        mack8, man_ack8, auto8;
  logic [7:0]  addr8, in8, out8;
  logic [11:0] data8, mdata8, man_data8, cur8;
  int          dly8 = 0, cnt8 = 0;

  assign ack8  = auto8 ? mack8 : man_ack8;
  assign data8 = auto8 ? mdata8 : man_data8;

  td4x_core #(.W(8)) dut8 (
    .clk(clk), .rst(rst8), .run(run8),
    .imem_req(req8), .imem_addr(addr8),
    .imem_ack(ack8), .imem_data(data8),
    .in_data(in8), .out_data(out8),
    .out_valid(ov8), .halted(halt8)
  );

  always @(negedge clk) begin
    if (req8) begin
      if (cnt8 == dly8) begin
        mack8  <= 1'b1;
        mdata8 <= cur8;
      end else begin
        mack8 <= 1'b0;
        cnt8  <= cnt8 + 1;
      end
    end else begin
      mack8 <= 1'b0;
      cnt8  <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_instr4(input logic [7:0] ins, input logic [3:0] ind,
                           output logic [3:0] fa);
    int n;
    cur4 = ins;
    in4  = ind;
    n = 0;
    while (!req4 && n < 20) begin @(posedge clk); #1; n++; end
    if (!req4) begin
      errors++;
      $display("FAIL fetch4_start timeout act=0 exp=1");
    end
    fa = addr4;
    n = 0;
    while (req4 && n < 20) begin @(posedge clk); #1; n++; end
    if (req4) begin
      errors++;
      $display("FAIL fetch4_ack timeout act=1 exp=0");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_instr8(input logic [11:0] ins, input logic drop,
                           output logic [7:0] fa);
    int n;
    cur8 = ins;
    n = 0;
    while (!req8 && n < 20) begin @(posedge clk); #1; n++; end
    if (!req8) begin
      errors++;
      $display("FAIL fetch8_start timeout act=0 exp=1");
    end
    fa = addr8;
    if (drop) run8 = 1'b0;
    n = 0;
    while (req8 && n < 20) begin @(posedge clk); #1; n++; end
    if (req8) begin
      errors++;
      $display("FAIL fetch8_ack timeout act=1 exp=0");
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [3:0] ind;
    logic [3:0] addr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ip;
    logic [3:0] out;
    logic       cf;
    logic       ov;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [3:0] fa4;
    logic [7:0] fa8;
    int         n;

    //          ins    in    addr  a     b     ip    out   cf    ov
    tbl[0]  = '{8'h33, 4'h0, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{8'h05, 4'h0, 4'h1, 4'h8, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{8'h09, 4'h0, 4'h2, 4'h1, 4'h0, 4'h3, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{8'hE0, 4'h0, 4'h3, 4'h1, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{8'h32, 4'h0, 4'h4, 4'h2, 4'h0, 4'h5, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{8'hA5, 4'h0, 4'h5, 4'hD, 4'h0, 4'h6, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{8'hC7, 4'h0, 4'h6, 4'hD, 4'h0, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{8'h76, 4'h0, 4'h7, 4'hD, 4'h6, 4'h8, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{8'h90, 4'h0, 4'h8, 4'hD, 4'h6, 4'h9, 4'h6, 1'b0, 1'b1};
    tbl[9]  = '{8'hB9, 4'h0, 4'h9, 4'hD, 4'h6, 4'hA, 4'h9, 1'b0, 1'b1};
    tbl[10] = '{8'h20, 4'hC, 4'hA, 4'hC, 4'h6, 4'hB, 4'h9, 1'b0, 1'b0};
    tbl[11] = '{8'h40, 4'h0, 4'hB, 4'hC, 4'hC, 4'hC, 4'h9, 1'b0, 1'b0};
    tbl[12] = '{8'h60, 4'h5, 4'hC, 4'hC, 4'h5, 4'hD, 4'h9, 1'b0, 1'b0};
    tbl[13] = '{8'h10, 4'h0, 4'hD, 4'h5, 4'h5, 4'hE, 4'h9, 1'b0, 1'b0};
    tbl[14] = '{8'h5C, 4'h0, 4'hE, 4'h5, 4'h1, 4'hF, 4'h9, 1'b1, 1'b0};
    tbl[15] = '{8'h00, 4'h0, 4'hF, 4'h5, 4'h1, 4'h0, 4'h9, 1'b0, 1'b0};
    tbl[16] = '{8'h80, 4'h0, 4'h0, 4'h6, 4'h1, 4'h1, 4'h9, 1'b0, 1'b0};
    tbl[17] = '{8'hFE, 4'h0, 4'h1, 4'h6, 4'h1, 4'hE, 4'h9, 1'b0, 1'b0};
    tbl[18] = '{8'h0B, 4'h0, 4'hE, 4'h1, 4'h1, 4'hF, 4'h9, 1'b1, 1'b0};
    tbl[19] = '{8'h80, 4'h0, 4'hF, 4'h2, 4'h1, 4'h0, 4'h9, 1'b0, 1'b0};
    tbl[20] = '{8'hC3, 4'h0, 4'h0, 4'h2, 4'h1, 4'h1, 4'h9, 1'b0, 1'b0};
    tbl[21] = '{8'hE9, 4'h0, 4'h1, 4'h2, 4'h1, 4'h9, 4'h9, 1'b0, 1'b0};
    tbl[22] = '{8'h5F, 4'h0, 4'h9, 4'h2, 4'h0, 4'hA, 4'h9, 1'b1, 1'b0};
    tbl[23] = '{8'hF4, 4'h0, 4'hA, 4'h2, 4'h0, 4'h4, 4'h9, 1'b0, 1'b0};

    rst4 = 1'b1; run4 = 1'b1; in4 = '0; cur4 = '0;
    rst8 = 1'b1; run8 = 1'b0; in8 = '0; cur8 = '0;
    auto8 = 1'b1; man_ack8 = 1'b0; man_data8 = '0;

    // reset with run already high
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_req", req4, 0);
      chk("rst_addr", addr4, 0);
      chk("rst_out", out4, 0);
      chk("rst_ov", ov4, 0);
      chk("rst_halt", halt4, 0);
    end
    rst4 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", req4, 1);
    chk("post_rst_addr", addr4, 0);

    for (int i = 0; i < 24; i++) begin
      do_instr4(tbl[i].ins, tbl[i].ind, fa4);
      chk($sformatf("v%0d_fetch", i), fa4, tbl[i].addr);
      chk($sformatf("v%0d_a", i), dut4.regs_q.a, tbl[i].a);
      chk($sformatf("v%0d_b", i), dut4.regs_q.b, tbl[i].b);
      chk($sformatf("v%0d_cf", i), dut4.regs_q.cf, tbl[i].cf);
      chk($sformatf("v%0d_ip", i), addr4, tbl[i].ip);
      chk($sformatf("v%0d_out", i), out4, tbl[i].out);
      chk($sformatf("v%0d_ov", i), ov4, tbl[i].ov);
    end

    // three wait states: request held, registers frozen
    dly4 = 3;
    cur4 = 8'h37;
    chk("ws_addr0", addr4, 4);
    n = 0;
    while (req4 && n < 20) begin
      @(posedge clk); #1; n++;
      if (req4) chk("ws_addr_stable", addr4, 4);
      chk("ws_a_frozen", dut4.regs_q.a, 2);
    end
    chk("ws_req_cycles", n, 4);
    @(posedge clk); #1;
    chk("ws_a_new", dut4.regs_q.a, 7);
    chk("ws_next_req", req4, 1);
    chk("ws_next_addr", addr4, 5);

    // OUT strobe is a single cycle, HLT parks the core
    do_instr4(8'hB3, 4'h0, fa4);
    chk("out3_ov", ov4, 1);
    chk("out3_data", out4, 3);
    @(posedge clk); #1;
    chk("out3_ov_drop", ov4, 0);
    chk("out3_hold", out4, 3);
    do_instr4(8'h0F, 4'h0, fa4);
    chk("pre_hlt_a", dut4.regs_q.a, 6);
    chk("pre_hlt_cf", dut4.regs_q.cf, 1);
    do_instr4(8'hD0, 4'h0, fa4);
    chk("hlt_halted", halt4, 1);
    chk("hlt_cf", dut4.regs_q.cf, 0);
    chk("hlt_a", dut4.regs_q.a, 6);
    chk("hlt_ip", addr4, 7);
    repeat (6) begin
      @(posedge clk); #1;
      chk("hlt_noreq", req4, 0);
      chk("hlt_stay", halt4, 1);
    end
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("hlt_rst_halt", halt4, 0);
    chk("hlt_rst_ip", addr4, 0);
    chk("hlt_rst_out", out4, 0);

    // W=8 block
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_idle_noreq", req8, 0);
    run8 = 1'b1;
    do_instr8(12'h32C, 1'b0, fa8);
    chk("w8_mov_fetch", fa8, 0);
    chk("w8_mov_a", dut8.regs_q.a, 44);
    do_instr8(12'h0C8, 1'b0, fa8);
    chk("w8_add1_a", dut8.regs_q.a, 244);
    chk("w8_add1_cf", dut8.regs_q.cf, 0);
    do_instr8(12'h0C8, 1'b0, fa8);
    chk("w8_add2_a", dut8.regs_q.a, 188);
    chk("w8_add2_cf", dut8.regs_q.cf, 1);
    do_instr8(12'hAC8, 1'b0, fa8);
    chk("w8_sub_a", dut8.regs_q.a, 244);
    chk("w8_sub_cf", dut8.regs_q.cf, 1);
    chk("w8_sub_ip", addr8, 4);

    // run dropped mid-fetch
    dly8 = 2;
    do_instr8(12'h701, 1'b1, fa8);
    chk("w8_gate_b", dut8.regs_q.b, 1);
    chk("w8_gate_ip", addr8, 5);
    repeat (3) begin
      chk("w8_gate_noreq", req8, 0);
      @(posedge clk); #1;
    end
    chk("w8_gate_ip_hold", addr8, 5);

    dly8 = 0;
    run8 = 1'b1;
    do_instr8(12'hFF0, 1'b0, fa8);
    chk("w8_jmp_fetch", fa8, 5);
    chk("w8_jmp_ip", addr8, 8'hF0);

    // reset with a fetch outstanding, then a late ack
    auto8 = 1'b0;
    chk("w8_mid_req", req8, 1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_mid_rst_req", req8, 0);
    rst8 = 1'b0;
    run8 = 1'b0;
    man_ack8 = 1'b1;
    man_data8 = 12'h355;
    @(posedge clk); #1;
    man_ack8 = 1'b0;
    chk("w8_late_ir", dut8.ir_q, 0);
    chk("w8_late_a", dut8.regs_q.a, 0);
    chk("w8_late_req", req8, 0);
    chk("w8_late_addr", addr8, 0);
    @(posedge clk); #1;
    chk("w8_late_idle", req8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
